// File: rtl/rv_pipe_tracker_pkg.sv
// Shared types for the pipeline register-file metadata tracker.
// One record per in-flight instruction; an all-zero record is a bubble.
package rv_pipe_tracker_pkg;

  localparam int RF_AW = 5;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] ra1;
    logic [RF_AW-1:0] ra2;
    logic [RF_AW-1:0] wa;
    logic             we;
    logic             is_load;
  } trk_rec_t;

  localparam int       TRK_REC_W  = $bits(trk_rec_t);
  localparam trk_rec_t TRK_BUBBLE = '0;

  // What the ID->EX register captures this cycle.
  typedef enum logic [1:0] {
    SLOT_PASS,
    SLOT_BUBBLE,
    SLOT_FLUSH
  } slot_e;

  // Flush wins over stall so a coincident pair is counted once, as a flush.
  function automatic slot_e slot_sel(logic flush, logic stall);
    if (flush) return SLOT_FLUSH;
    if (stall) return SLOT_BUBBLE;
    return SLOT_PASS;
  endfunction

  // Write-enable and load flag only survive for a real instruction; x0 writes
  // are optionally dropped so hazard logic never forwards from x0.
  function automatic trk_rec_t make_rec(logic valid, logic [RF_AW-1:0] ra1,
                                        logic [RF_AW-1:0] ra2, logic [RF_AW-1:0] wa,
                                        logic we, logic is_load, logic gate_x0);
    trk_rec_t r;
    r.valid   = valid;
    r.ra1     = ra1;
    r.ra2     = ra2;
    r.wa      = wa;
    r.we      = we & valid & ~(gate_x0 & (wa == '0));
    r.is_load = is_load & valid;
    return r;
  endfunction

endpackage

// File: rtl/rv_pipe_tracker_if.sv
// ID-side inputs and per-stage tracking outputs of the pipeline tracker.
// master drives the ID fields and control, slave is the tracker.
interface rv_pipe_tracker_if #(
  parameter int CNT_W = 32
);
  logic             i_trk_valid_id;
  logic [4:0]       i_trk_ra1_id;
  logic [4:0]       i_trk_ra2_id;
  logic [4:0]       i_trk_wa_id;
  logic             i_trk_we_id;
  logic             i_trk_is_load_id;
  logic             i_trk_stall_ifid;
  logic             i_trk_flush;

  logic [4:0]       o_trk_rf_ra1_ex;
  logic [4:0]       o_trk_rf_ra2_ex;
  logic [4:0]       o_trk_rf_wa_mem;
  logic [4:0]       o_trk_rf_wa_wb;
  logic             o_trk_rf_we_mem;
  logic             o_trk_rf_we_wb;
  logic             o_trk_is_load_mem;
  logic             o_trk_is_load_wb;
  logic             o_trk_valid_ex;
  logic             o_trk_valid_mem;
  logic             o_trk_valid_wb;
  logic [CNT_W-1:0] o_trk_bubble_cnt;
  logic [CNT_W-1:0] o_trk_flush_cnt;
  logic [CNT_W-1:0] o_trk_retire_cnt;

  modport master (
    output i_trk_valid_id, i_trk_ra1_id, i_trk_ra2_id, i_trk_wa_id,
           i_trk_we_id, i_trk_is_load_id, i_trk_stall_ifid, i_trk_flush,
    input  o_trk_rf_ra1_ex, o_trk_rf_ra2_ex, o_trk_rf_wa_mem, o_trk_rf_wa_wb,
           o_trk_rf_we_mem, o_trk_rf_we_wb, o_trk_is_load_mem, o_trk_is_load_wb,
           o_trk_valid_ex, o_trk_valid_mem, o_trk_valid_wb,
           o_trk_bubble_cnt, o_trk_flush_cnt, o_trk_retire_cnt
  );

  modport slave (
    input  i_trk_valid_id, i_trk_ra1_id, i_trk_ra2_id, i_trk_wa_id,
           i_trk_we_id, i_trk_is_load_id, i_trk_stall_ifid, i_trk_flush,
    output o_trk_rf_ra1_ex, o_trk_rf_ra2_ex, o_trk_rf_wa_mem, o_trk_rf_wa_wb,
           o_trk_rf_we_mem, o_trk_rf_we_wb, o_trk_is_load_mem, o_trk_is_load_wb,
           o_trk_valid_ex, o_trk_valid_mem, o_trk_valid_wb,
           o_trk_bubble_cnt, o_trk_flush_cnt, o_trk_retire_cnt
  );

endinterface

// File: rtl/rv_pipe_tracker_stage_reg.sv
// One pipeline-stage metadata register: 1-cycle latency, no backpressure;
// bubble_i replaces the incoming record with the all-zero bubble.
module rv_pipe_tracker_stage_reg
  import rv_pipe_tracker_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     bubble_i,
  input  trk_rec_t rec_i,
  output trk_rec_t rec_o
);

  trk_rec_t rec_q;
  trk_rec_t rec_d;

  always_comb begin
    rec_d = bubble_i ? TRK_BUBBLE : rec_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rec_q <= TRK_BUBBLE;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/rv_pipe_tracker.sv
// Tracks RF metadata through ID/EX, EX/MEM, MEM/WB: EX +1, MEM +2, WB +3 cycles.
// Stall/flush only bubble the EX entry; MEM and WB always advance.
module rv_pipe_tracker
  import rv_pipe_tracker_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit GATE_X0 = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rv_pipe_tracker_if.slave   trk
);

  trk_rec_t rec_id;
  trk_rec_t rec_ex;
  trk_rec_t rec_mem;
  trk_rec_t rec_wb;
  slot_e    slot;
  logic     ex_bubble;

  always_comb begin
    rec_id = make_rec(trk.i_trk_valid_id, trk.i_trk_ra1_id, trk.i_trk_ra2_id,
                      trk.i_trk_wa_id, trk.i_trk_we_id, trk.i_trk_is_load_id,
                      GATE_X0);
    slot      = slot_sel(trk.i_trk_flush, trk.i_trk_stall_ifid);
    ex_bubble = (slot != SLOT_PASS);
  end

  rv_pipe_tracker_stage_reg u_stage_ex (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .bubble_i (ex_bubble),
    .rec_i    (rec_id),
    .rec_o    (rec_ex)
  );

  rv_pipe_tracker_stage_reg u_stage_mem (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .bubble_i (1'b0),
    .rec_i    (rec_ex),
    .rec_o    (rec_mem)
  );

  rv_pipe_tracker_stage_reg u_stage_wb (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .bubble_i (1'b0),
    .rec_i    (rec_mem),
    .rec_o    (rec_wb)
  );

  // Sources are consumed only in EX; WB keeps them solely so the record stays uniform.
  logic wb_src_unused;
  assign wb_src_unused = ^{rec_wb.ra1, rec_wb.ra2};

  // Saturating event counters: 0 = bubble, 1 = flush, 2 = retire.
  localparam int NCNT = 3;

  logic [NCNT-1:0]  cnt_inc;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];

  always_comb begin
    cnt_inc[0] = (slot == SLOT_BUBBLE);
    cnt_inc[1] = (slot == SLOT_FLUSH);
    cnt_inc[2] = rec_wb.valid;
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_inc[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign trk.o_trk_rf_ra1_ex   = rec_ex.ra1;
  assign trk.o_trk_rf_ra2_ex   = rec_ex.ra2;
  assign trk.o_trk_valid_ex    = rec_ex.valid;
  assign trk.o_trk_rf_wa_mem   = rec_mem.wa;
  assign trk.o_trk_rf_we_mem   = rec_mem.we;
  assign trk.o_trk_is_load_mem = rec_mem.is_load;
  assign trk.o_trk_valid_mem   = rec_mem.valid;
  assign trk.o_trk_rf_wa_wb    = rec_wb.wa;
  assign trk.o_trk_rf_we_wb    = rec_wb.we;
  assign trk.o_trk_is_load_wb  = rec_wb.is_load;
  assign trk.o_trk_valid_wb    = rec_wb.valid;
  assign trk.o_trk_bubble_cnt  = cnt_q[0];
  assign trk.o_trk_flush_cnt   = cnt_q[1];
  assign trk.o_trk_retire_cnt  = cnt_q[2];

endmodule

// File: tb/tb_rv_pipe_tracker.sv
// Bench for rv_pipe_tracker: two instances (32-bit counters with x0 gating,
// 3-bit counters without) driven identically and checked against a history model.
module tb_rv_pipe_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_we, id_ld, stall, flush;
  logic [4:0] id_ra1, id_ra2, id_wa;

  int checks = 0;
  int errors = 0;

  rv_pipe_tracker_if #(.CNT_W(32)) trk_a ();
  rv_pipe_tracker_if #(.CNT_W(3))  trk_b ();

  assign trk_a.i_trk_valid_id   = id_valid;
  assign trk_a.i_trk_ra1_id     = id_ra1;
  assign trk_a.i_trk_ra2_id     = id_ra2;
  assign trk_a.i_trk_wa_id      = id_wa;
  assign trk_a.i_trk_we_id      = id_we;
  assign trk_a.i_trk_is_load_id = id_ld;
  assign trk_a.i_trk_stall_ifid = stall;
  assign trk_a.i_trk_flush      = flush;
  assign trk_b.i_trk_valid_id   = id_valid;
  assign trk_b.i_trk_ra1_id     = id_ra1;
  assign trk_b.i_trk_ra2_id     = id_ra2;
  assign trk_b.i_trk_wa_id      = id_wa;
  assign trk_b.i_trk_we_id      = id_we;
  assign trk_b.i_trk_is_load_id = id_ld;
  assign trk_b.i_trk_stall_ifid = stall;
  assign trk_b.i_trk_flush      = flush;

  rv_pipe_tracker #(.CNT_W(32), .GATE_X0(1'b1)) dut_a (.i_clk(clk), .i_rst(rst), .trk(trk_a));
  rv_pipe_tracker #(.CNT_W(3),  .GATE_X0(1'b0)) dut_b (.i_clk(clk), .i_rst(rst), .trk(trk_b));

  // Model: the last three records that entered EX, oldest first ([0]=WB, [2]=EX).
  typedef struct packed {
    bit       v;
    bit [4:0] ra1, ra2, wa;
    bit       we, ld;
  } mrec_t;

  mrec_t qa[$];
  mrec_t qb[$];
  int unsigned n_bubble, n_flush, n_retire;

  task automatic model_reset();
    qa = {mrec_t'(0), mrec_t'(0), mrec_t'(0)};
    qb = {mrec_t'(0), mrec_t'(0), mrec_t'(0)};
    n_bubble = 0;
    n_flush  = 0;
    n_retire = 0;
  endtask

  task automatic model_edge();
    mrec_t ea, eb;
    if (rst) return;
    if (qa[0].v) n_retire++;
    if (flush) n_flush++;
    else if (stall) n_bubble++;
    ea = '0;
    eb = '0;
    if (!flush && !stall) begin
      ea.v   = id_valid;
      ea.ra1 = id_ra1;
      ea.ra2 = id_ra2;
      ea.wa  = id_wa;
      ea.we  = id_we && id_valid && (id_wa != 5'd0);
      ea.ld  = id_ld && id_valid;
      eb     = ea;
      eb.we  = id_we && id_valid;
    end
    qa.push_back(ea);
    qb.push_back(eb);
    void'(qa.pop_front());
    void'(qb.pop_front());
  endtask

  function automatic int unsigned sat(int unsigned n, int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".a.ra1_ex"},   32'(trk_a.o_trk_rf_ra1_ex),   32'(qa[2].ra1));
    chk({ph, ".a.ra2_ex"},   32'(trk_a.o_trk_rf_ra2_ex),   32'(qa[2].ra2));
    chk({ph, ".a.valid_ex"}, 32'(trk_a.o_trk_valid_ex),    32'(qa[2].v));
    chk({ph, ".a.wa_mem"},   32'(trk_a.o_trk_rf_wa_mem),   32'(qa[1].wa));
    chk({ph, ".a.we_mem"},   32'(trk_a.o_trk_rf_we_mem),   32'(qa[1].we));
    chk({ph, ".a.ld_mem"},   32'(trk_a.o_trk_is_load_mem), 32'(qa[1].ld));
    chk({ph, ".a.v_mem"},    32'(trk_a.o_trk_valid_mem),   32'(qa[1].v));
    chk({ph, ".a.wa_wb"},    32'(trk_a.o_trk_rf_wa_wb),    32'(qa[0].wa));
    chk({ph, ".a.we_wb"},    32'(trk_a.o_trk_rf_we_wb),    32'(qa[0].we));
    chk({ph, ".a.ld_wb"},    32'(trk_a.o_trk_is_load_wb),  32'(qa[0].ld));
    chk({ph, ".a.v_wb"},     32'(trk_a.o_trk_valid_wb),    32'(qa[0].v));
    chk({ph, ".a.bubble"},   trk_a.o_trk_bubble_cnt,       n_bubble);
    chk({ph, ".a.flush"},    trk_a.o_trk_flush_cnt,        n_flush);
    chk({ph, ".a.retire"},   trk_a.o_trk_retire_cnt,       n_retire);
    chk({ph, ".b.ra1_ex"},   32'(trk_b.o_trk_rf_ra1_ex),   32'(qb[2].ra1));
    chk({ph, ".b.valid_ex"}, 32'(trk_b.o_trk_valid_ex),    32'(qb[2].v));
    chk({ph, ".b.we_mem"},   32'(trk_b.o_trk_rf_we_mem),   32'(qb[1].we));
    chk({ph, ".b.we_wb"},    32'(trk_b.o_trk_rf_we_wb),    32'(qb[0].we));
    chk({ph, ".b.wa_wb"},    32'(trk_b.o_trk_rf_wa_wb),    32'(qb[0].wa));
    chk({ph, ".b.bubble"},   32'(trk_b.o_trk_bubble_cnt),  sat(n_bubble, 7));
    chk({ph, ".b.flush"},    32'(trk_b.o_trk_flush_cnt),   sat(n_flush, 7));
    chk({ph, ".b.retire"},   32'(trk_b.o_trk_retire_cnt),  sat(n_retire, 7));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] wa, input logic we, input logic ld);
    id_valid = v;
    id_ra1   = r1;
    id_ra2   = r2;
    id_wa    = wa;
    id_we    = we;
    id_ld    = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  int unsigned base_retire;
  int unsigned base_bubble;

  initial begin
    idle();
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Straight-line flow of a load to x5.
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    step("sl0");
    idle();
    step("sl1");
    chk("sl.wa_mem", 32'(trk_a.o_trk_rf_wa_mem), 32'd5);
    chk("sl.ld_mem", 32'(trk_a.o_trk_is_load_mem), 32'd1);
    step("sl2");
    chk("sl.wa_wb", 32'(trk_a.o_trk_rf_wa_wb), 32'd5);
    chk("sl.we_wb", 32'(trk_a.o_trk_rf_we_wb), 32'd1);
    step("sl3");
    chk("sl.retire", trk_a.o_trk_retire_cnt, 32'd1);

    // Write to x0: gated in dut_a, kept in dut_b.
    set_id(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0);
    step("x0_0");
    idle();
    step("x0_1");
    chk("x0.a.we_mem", 32'(trk_a.o_trk_rf_we_mem), 32'd0);
    step("x0_2");
    chk("x0.a.we_wb", 32'(trk_a.o_trk_rf_we_wb), 32'd0);
    chk("x0.a.v_wb", 32'(trk_a.o_trk_valid_wb), 32'd1);
    chk("x0.b.we_wb", 32'(trk_b.o_trk_rf_we_wb), 32'd1);
    step("x0_3");
    chk("x0.retire", trk_a.o_trk_retire_cnt, 32'd2);

    // Load-use stall for two cycles with ID held.
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    stall = 1'b1;
    step("st0");
    chk("st0.valid_ex", 32'(trk_a.o_trk_valid_ex), 32'd0);
    chk("st0.ra1_ex", 32'(trk_a.o_trk_rf_ra1_ex), 32'd0);
    step("st1");
    chk("st1.valid_ex", 32'(trk_a.o_trk_valid_ex), 32'd0);
    stall = 1'b0;
    step("st2");
    chk("st2.ra1_ex", 32'(trk_a.o_trk_rf_ra1_ex), 32'd5);
    chk("st2.bubble", trk_a.o_trk_bubble_cnt, 32'd2);
    idle();
    for (int i = 0; i < 3; i++) step("st_drain");

    // Flush and stall together behind two older instructions.
    set_id(1'b1, 5'd1, 5'd1, 5'd8, 1'b1, 1'b0);
    step("fs0");
    set_id(1'b1, 5'd2, 5'd2, 5'd9, 1'b1, 1'b0);
    step("fs1");
    base_retire = n_retire;
    set_id(1'b1, 5'd3, 5'd3, 5'd10, 1'b1, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    step("fs2");
    chk("fs.valid_ex", 32'(trk_a.o_trk_valid_ex), 32'd0);
    chk("fs.flush", trk_a.o_trk_flush_cnt, 32'd1);
    chk("fs.bubble", trk_a.o_trk_bubble_cnt, 32'd2);
    idle();
    for (int i = 0; i < 3; i++) step("fs_drain");
    chk("fs.retire", trk_a.o_trk_retire_cnt, base_retire + 2);

    // Async reset with three instructions in flight.
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 11), 1'b1, 1'b1);
      step("rs_fill");
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rs.valid_ex", 32'(trk_a.o_trk_valid_ex), 32'd0);
    chk("rs.valid_wb", 32'(trk_a.o_trk_valid_wb), 32'd0);
    chk("rs.retire", trk_a.o_trk_retire_cnt, 32'd0);
    check_outputs("rs_async");
    step("rs_hold");
    rst = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) step("rs_after");
    chk("rs.retire_after", trk_a.o_trk_retire_cnt, 32'd0);

    // Ten back-to-back valid instructions: 3-bit counter saturates at 7.
    for (int i = 0; i < 10; i++) begin
      set_id(1'b1, 5'(i), 5'(i + 3), 5'(i + 1), 1'b1, 1'b0);
      step("sat_fill");
    end
    idle();
    for (int i = 0; i < 3; i++) step("sat_drain");
    chk("sat.b.retire", 32'(trk_b.o_trk_retire_cnt), 32'd7);
    chk("sat.a.retire", trk_a.o_trk_retire_cnt, 32'd10);

    // Random traffic with occasional stalls, flushes and resets.
    base_bubble = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rnd_rst");
        step("rnd_rst_hold");
        rst = 1'b0;
      end else begin
        set_id(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
               5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), 1'($urandom));
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 7) == 0);
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_pipe_tracker.md
Name: rv_pipe_tracker

Overview:
- Producer-side companion to the pipeline hazard/forwarding logic.
- Tracks register-file source/destination metadata of every in-flight instruction through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Obeys the stall and flush requests coming back from the hazard logic and branch unit, inserting bubbles as required.
- Supplies the per-stage address/write-enable/load flags that the hazard logic consumes, plus stage-valid bits and performance counters.

Parameters:
- CNT_W, 32, width of the bubble, flush and retire counters (saturating).
- GATE_X0, 1, when 1 a destination of x0 forces the tracked write-enable to 0 in every stage.

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_trk_valid_id  in  1  ID stage holds a real instruction
- i_trk_ra1_id  in  5  rs1 of ID instruction
- i_trk_ra2_id  in  5  rs2 of ID instruction
- i_trk_wa_id  in  5  rd of ID instruction
- i_trk_we_id  in  1  ID instruction writes RF
- i_trk_is_load_id  in  1  ID instruction is a load
- i_trk_stall_ifid  in  1  load-use stall request; insert bubble into EX
- i_trk_flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX
- o_trk_rf_ra1_ex, o_trk_rf_ra2_ex  out  5 each  sources of EX instruction
- o_trk_rf_wa_mem, o_trk_rf_wa_wb  out  5 each  destinations in MEM/WB
- o_trk_rf_we_mem, o_trk_rf_we_wb  out  1 each  write-enables in MEM/WB
- o_trk_is_load_mem, o_trk_is_load_wb  out  1 each  load flags in MEM/WB
- o_trk_valid_ex, o_trk_valid_mem, o_trk_valid_wb  out  1 each  stage-valid bits
- o_trk_bubble_cnt  out  CNT_W  count of stall-inserted bubbles
- o_trk_flush_cnt  out  CNT_W  count of flush-killed slots
- o_trk_retire_cnt  out  CNT_W  count of valid instructions leaving WB

Behaviour:
- Reset (async, i_rst=1): all stage fields, valid bits and counters are 0; outputs are 0 immediately, without waiting for a clock edge.
- Stage record: {valid, ra1, ra2, wa, we, is_load}.
- Bubble record: all fields 0.
- we_eff = i_trk_we_id & i_trk_valid_id & ~(GATE_X0 & wa==0).
- is_load_eff = i_trk_is_load_id & i_trk_valid_id.
- ID->EX on each rising edge:
  - If i_trk_flush or i_trk_stall_ifid: EX loads the bubble record.
  - Otherwise EX loads {i_trk_valid_id, ra1, ra2, wa, we_eff, is_load_eff}.
- EX->MEM and MEM->WB advance unconditionally every cycle. The stall holds only IF/ID; there is no back-pressure past EX.
- Outputs are direct register outputs. The latency from an ID field to the EX output is 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- Flush and stall asserted in the same cycle: a single bubble is inserted and counted only in o_trk_flush_cnt.
- o_trk_bubble_cnt increments by 1 per cycle with stall=1 and flush=0.
- o_trk_flush_cnt increments by 1 per cycle with flush=1, regardless of i_trk_valid_id.
- o_trk_retire_cnt increments on each edge where o_trk_valid_wb=1.
- All counters saturate at 2^CNT_W-1 and never wrap.
- A stall persisting N cycles inserts N bubbles. The ID inputs are held externally and captured on the first non-stall cycle.
- Reset asserted mid-operation clears all in-flight records; no partial retire is counted.

Decomposition:
- rv_configs.v gains `RF_AW (5), `TRK_REC_W (record width = 1+5+5+5+1+1 = 18) and `TRK_BUBBLE (all-zero record constant).
- One natural sub-module: rv_trk_stage_reg, a single stage register of `TRK_REC_W with async reset and a synchronous bubble-load input. It is instantiated 3 times; MEM and WB tie bubble-load to 0.
- The counters are inline saturating logic, three instances of the same pattern.

Test Plan:
- Reset mid-stream: inject 3 valid instructions, assert i_rst asynchronously between edges -> all outputs 0 immediately, retire_cnt stays 0 after deassert.
- Straight-line flow: ID {valid=1, wa=5, we=1, load=1} at cycle 0 -> wa_mem=5, is_load_mem=1 at cycle 2; wa_wb=5, we_wb=1 at cycle 3; retire_cnt=1 after cycle 4.
- x0 gating: ID {wa=0, we=1} with GATE_X0=1 -> we_mem=0 and we_wb=0, valid_wb=1, retire_cnt increments.
- Load-use stall: stall=1 for 2 cycles with ID {ra1=5} held -> EX shows 2 bubbles (valid_ex=0, ra1_ex=0), then ra1_ex=5; bubble_cnt=2.
- Flush plus stall together: flush=1 and stall=1 for 1 cycle -> one bubble in EX, flush_cnt=1, bubble_cnt=0; the older MEM/WB instructions still retire.
- Saturation: CNT_W=3, run 10 valid instructions -> retire_cnt stops at 7.
